// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms the capture unit, forces auto-mode triggers and commits frames during vblank.
// Optional macro ACQ_HOLDOFF_EN adds a post-commit HOLDOFF state that rate-limits screen updates.
module acq_sequencer #(
  parameter int TIMEOUT_CYCLES = 1_300_000,
  parameter int HOLDOFF_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       run_toggle,
  input  logic       single_rearm,
  input  logic       trig_hit,
  input  logic       cap_done,
  input  logic       vblank,
  output logic       arm,
  output logic       force_trig,
  output logic       commit,
  output logic       running,
  output logic       triggered,
  output logic [7:0] frame_cnt,
  output logic [2:0] state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1 || HOLDOFF_CYCLES < 1) begin : g_bad_params
    $error("acq_sequencer: TIMEOUT_CYCLES and HOLDOFF_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_STOP        = 3'd0,
    S_ARM         = 3'd1,
    S_WAIT_TRIG   = 3'd2,
    S_CAPTURE     = 3'd3,
    S_WAIT_VBLANK = 3'd4,
    S_COMMIT      = 3'd5,
    S_HOLD        = 3'd6,
    S_HOLDOFF     = 3'd7
  } state_e;

  state_e        st_r;
  logic [1:0]    mode_r;
  logic          trig_r;
  logic          stop_pending_r;
  logic [TW-1:0] tcnt_r;

`ifdef ACQ_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES - 1);
  logic [HW-1:0] hcnt_r;
`endif

  assign state = st_r;

  // Sequencer state, latched acquisition context and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r           <= S_STOP;
      mode_r         <= 2'b00;
      trig_r         <= 1'b0;
      stop_pending_r <= 1'b0;
      tcnt_r         <= '0;
`ifdef ACQ_HOLDOFF_EN
      hcnt_r         <= '0;
`endif
      arm            <= 1'b0;
      force_trig     <= 1'b0;
      commit         <= 1'b0;
      running        <= 1'b0;
      triggered      <= 1'b0;
      frame_cnt      <= 8'd0;
    end else begin
      arm        <= 1'b0;
      force_trig <= 1'b0;
      commit     <= 1'b0;
      case (st_r)
        S_STOP: begin
          stop_pending_r <= 1'b0;
          if (run_toggle || (single_rearm && mode == 2'b10)) begin
            st_r    <= S_ARM;
            arm     <= 1'b1;
            running <= 1'b1;
          end else begin
            st_r <= S_STOP;
          end
        end
        S_ARM: begin
          mode_r         <= mode;
          tcnt_r         <= '0;
          stop_pending_r <= 1'b0;
          st_r           <= S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (run_toggle) begin
            st_r    <= S_STOP;
            running <= 1'b0;
          end else if (trig_hit) begin
            st_r   <= S_CAPTURE;
            trig_r <= 1'b1;
          end else if (mode_r == 2'b00 && tcnt_r == T_LAST) begin
            st_r       <= S_CAPTURE;
            trig_r     <= 1'b0;
            force_trig <= 1'b1;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        S_CAPTURE: begin
          // A stop request lets the in-flight frame finish; a second toggle withdraws it
          if (run_toggle) begin
            stop_pending_r <= ~stop_pending_r;
          end else begin
            stop_pending_r <= stop_pending_r;
          end
          if (cap_done) begin
            st_r <= S_WAIT_VBLANK;
          end else begin
            st_r <= S_CAPTURE;
          end
        end
        S_WAIT_VBLANK: begin
          if (run_toggle) begin
            stop_pending_r <= ~stop_pending_r;
          end else begin
            stop_pending_r <= stop_pending_r;
          end
          if (vblank) begin
            st_r      <= S_COMMIT;
            commit    <= 1'b1;
            triggered <= trig_r;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            st_r <= S_WAIT_VBLANK;
          end
        end
        S_COMMIT: begin
          if (stop_pending_r || run_toggle) begin
            st_r    <= S_STOP;
            running <= 1'b0;
          end else if (mode_r == 2'b10) begin
            st_r <= S_HOLD;
          end else begin
`ifdef ACQ_HOLDOFF_EN
            st_r   <= S_HOLDOFF;
            hcnt_r <= '0;
`else
            st_r <= S_ARM;
            arm  <= 1'b1;
`endif
          end
        end
        S_HOLD: begin
          if (run_toggle) begin
            st_r    <= S_STOP;
            running <= 1'b0;
          end else if (single_rearm) begin
            st_r <= S_ARM;
            arm  <= 1'b1;
          end else begin
            st_r <= S_HOLD;
          end
        end
`ifdef ACQ_HOLDOFF_EN
        S_HOLDOFF: begin
          if (run_toggle) begin
            st_r    <= S_STOP;
            running <= 1'b0;
          end else if (hcnt_r == H_LAST) begin
            st_r <= S_ARM;
            arm  <= 1'b1;
          end else begin
            hcnt_r <= hcnt_r + HW'(1);
          end
        end
`endif
        default: begin
          st_r    <= S_STOP;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: directed stimulus, a behavioural reference model and literal checks.
module tb_acq_sequencer;

  localparam int TIMEOUT = 100;
  localparam int HOLDOFF = 16;
`ifdef ACQ_HOLDOFF_EN
  localparam int AFTER_COMMIT = 7;
`else
  localparam int AFTER_COMMIT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic       run_toggle, single_rearm, trig_hit, cap_done, vblank;
  logic       arm, force_trig, commit, running, triggered;
  logic [7:0] frame_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  acq_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .HOLDOFF_CYCLES(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .mode(mode), .run_toggle(run_toggle),
    .single_rearm(single_rearm), .trig_hit(trig_hit), .cap_done(cap_done),
    .vblank(vblank), .arm(arm), .force_trig(force_trig), .commit(commit),
    .running(running), .triggered(triggered), .frame_cnt(frame_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: states numbered as on the debug output, pulses derived from state
  int m_state = 0, m_nxt = 0, m_mode = 0, m_cnt = 0, m_hcnt = 0, m_frames = 0;
  bit m_trig = 0, m_pend = 0, m_trigd = 0, m_force = 0, m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_mode = 0; m_cnt = 0; m_hcnt = 0; m_frames = 0;
      m_trig = 0; m_pend = 0; m_trigd = 0; m_force = 0; m_valid = 1;
    end else begin
      m_nxt = m_state;
      m_force = 0;
      case (m_state)
        0: if (run_toggle || (single_rearm && mode == 2)) m_nxt = 1;
        1: begin m_mode = mode; m_cnt = 0; m_pend = 0; m_nxt = 2; end
        2: begin
          if (run_toggle) m_nxt = 0;
          else if (trig_hit) begin m_nxt = 3; m_trig = 1; end
          else if (m_mode == 0 && m_cnt == TIMEOUT - 1) begin m_nxt = 3; m_trig = 0; m_force = 1; end
          else m_cnt++;
        end
        3: begin if (run_toggle) m_pend = !m_pend; if (cap_done) m_nxt = 4; end
        4: begin
          if (run_toggle) m_pend = !m_pend;
          if (vblank) begin m_nxt = 5; m_frames = (m_frames + 1) % 256; m_trigd = m_trig; end
        end
        5: begin
          if (m_pend || run_toggle) m_nxt = 0;
          else if (m_mode == 2) m_nxt = 6;
          else begin m_nxt = AFTER_COMMIT; m_hcnt = 0; end
        end
        6: if (run_toggle) m_nxt = 0; else if (single_rearm) m_nxt = 1;
        7: if (run_toggle) m_nxt = 0; else if (m_hcnt == HOLDOFF - 1) m_nxt = 1; else m_hcnt++;
        default: m_nxt = 0;
      endcase
      if (m_nxt == 0) m_pend = 0;
      m_state = m_nxt;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", state, m_state);
      chk("arm", arm, m_state == 1);
      chk("force_trig", force_trig, m_force);
      chk("commit", commit, m_state == 5);
      chk("running", running, m_state != 0);
      chk("triggered", triggered, m_trigd);
      chk("frame_cnt", frame_cnt, m_frames);
    end
  end

  // bits: {cap_done, trig_hit, single_rearm, run_toggle}
  task automatic pulse(input logic [3:0] m);
    {cap_done, trig_hit, single_rearm, run_toggle} = m;
    @(negedge clk);
    {cap_done, trig_hit, single_rearm, run_toggle} = 4'b0000;
  endtask

  task automatic wait_for_state(input int s, input string nm);
    int n;
    n = 0;
    while (state !== 3'(s) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, state, s);
  endtask

  task automatic vblank_commit();
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; mode = 2'b01; vblank = 1'b0;
    {cap_done, trig_hit, single_rearm, run_toggle} = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_running", running, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Normal flow
    pulse(4'b0001);
    chk("normal_arm", arm, 1);
    chk("normal_running", running, 1);
    repeat (9) @(negedge clk);
    pulse(4'b0100);
    chk("normal_capture", state, 3);
    repeat (299) @(negedge clk);
    pulse(4'b1000);
    repeat (50) @(negedge clk);
    chk("normal_waitvb", state, 4);
    vblank_commit();
    chk("normal_commit", commit, 1);
    chk("normal_triggered", triggered, 1);
    chk("normal_frame1", frame_cnt, 1);
    @(negedge clk);
    chk("normal_after", state, AFTER_COMMIT);

    // Stop while waiting for trigger: no commit
    wait_for_state(2, "stop_wt_reach");
    pulse(4'b0001);
    chk("stop_wt_state", state, 0);
    chk("stop_wt_frames", frame_cnt, 1);

    // Auto timeout
    mode = 2'b00;
    pulse(4'b0001);
    @(negedge clk);
    n = 0;
    while (force_trig !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("auto_timeout_cycles", n, TIMEOUT);
    chk("auto_capture", state, 3);
    pulse(4'b1000);
    vblank_commit();
    chk("auto_triggered", triggered, 0);
    chk("auto_frame2", frame_cnt, 2);

    // Stop requested during CAPTURE: frame still commits
    wait_for_state(2, "stopcap_reach");
    pulse(4'b0100);
    pulse(4'b0001);
    pulse(4'b1000);
    vblank_commit();
    chk("stopcap_commit", commit, 1);
    chk("stopcap_frame3", frame_cnt, 3);
    @(negedge clk);
    chk("stopcap_state", state, 0);
    chk("stopcap_running", running, 0);

    // Single shot
    mode = 2'b10;
    pulse(4'b0010);
    chk("single_arm", arm, 1);
    wait_for_state(2, "single_wt");
    pulse(4'b0100);
    pulse(4'b1000);
    vblank_commit();
    @(negedge clk);
    chk("single_hold", state, 6);
    repeat (20) @(negedge clk);
    chk("single_still_hold", state, 6);
    chk("single_no_arm", arm, 0);
    pulse(4'b0010);
    chk("single_rearm_arm", arm, 1);
    wait_for_state(2, "single_wt2");
    pulse(4'b0100);
    pulse(4'b1000);
    vblank_commit();
    @(negedge clk);
    pulse(4'b0001);
    chk("single_stop", state, 0);
    mode = 2'b01;
    pulse(4'b0010);
    chk("rearm_ignored_normal", state, 0);

    // Collision: trig_hit and run_toggle together
    pulse(4'b0001);
    wait_for_state(2, "coll_wt");
    pulse(4'b0101);
    chk("collision_stop", state, 0);

    // Double toggle in CAPTURE withdraws the stop request
    pulse(4'b0001);
    wait_for_state(2, "dbl_wt");
    pulse(4'b0100);
    pulse(4'b0001);
    pulse(4'b0001);
    pulse(4'b1000);
    vblank_commit();
    @(negedge clk);
    chk("dbl_toggle_continue", state, AFTER_COMMIT);

    // Frame counter wrap; vblank already high on WAIT_VBLANK entry
    for (int f = 0; f < 250; f++) begin
      wait_for_state(2, "wrap_wt");
      pulse(4'b0100);
      cap_done = 1'b1; vblank = 1'b1;
      @(negedge clk);
      cap_done = 1'b0;
      @(negedge clk);
      vblank = 1'b0;
      if (f == 0) chk("vblank_early_commit", commit, 1);
    end
    chk("wrap_frame_cnt", frame_cnt, 0);
    wait_for_state(2, "wrap_stop_wt");
    pulse(4'b0001);

    // Reset in WAIT_VBLANK
    pulse(4'b0001);
    wait_for_state(2, "rst_wt");
    pulse(4'b0100);
    pulse(4'b1000);
    chk("rst_in_waitvb", state, 4);
    rst = 1'b1; vblank = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_commit", commit, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_running", running, 0);
    chk("rst_triggered", triggered, 0);
    repeat (3) @(negedge clk);
    chk("rst_no_commit", state, 0);
    vblank = 1'b0;

`ifdef ACQ_HOLDOFF_EN
    pulse(4'b0001);
    wait_for_state(2, "ho_wt");
    pulse(4'b0100);
    pulse(4'b1000);
    vblank_commit();
    n = 0;
    while (arm !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("holdoff_arm_delay", n, HOLDOFF + 1);
    wait_for_state(2, "ho_stop_wt");
    pulse(4'b0001);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
